// File: rtl/seg_corr_demod.sv
// seg_corr_demod
// Receive-side correlator for the per-bit segment modulator. Each segment of
// SEG_LEN signed samples is multiplied against the reference waveform and
// summed. A non-negative correlation decides bit 1, a negative one decides
// bit 0. Decided bits are packed MSB-first into WORD_BITS-wide words.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   in_valid       sample_in / ref_sample_in are valid
//   in_ready       block accepts a sample this cycle
//   sample_in      received sample (signed, DW bits)
//   ref_sample_in  reference sample at ref_index (signed, DW bits)
//   ref_index      position within the current segment (drives the ref table)
//   bits_out       completed word, first decided bit in the MSB
//   bits_valid     bits_out holds a complete word
//   bits_ready     sink accepts the word
module seg_corr_demod #(
    parameter int DW        = 32,
    parameter int SEG_LEN   = 16,
    parameter int WORD_BITS = 32,
    parameter int IW        = $clog2(SEG_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] sample_in,
    input  logic signed [DW-1:0] ref_sample_in,
    output logic [IW-1:0]        ref_index,
    output logic [WORD_BITS-1:0] bits_out,
    output logic                 bits_valid,
    input  logic                 bits_ready
);

    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + IW;
    localparam int SW = $clog2(WORD_BITS);
    localparam int BW = $clog2(WORD_BITS + 1);

    localparam logic [IW-1:0] LAST_SAMPLE = IW'(SEG_LEN - 1);
    localparam logic [SW-1:0] LAST_SEG    = SW'(WORD_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(WORD_BITS - 1);

    logic [IW-1:0]        sample_cnt;
    logic [SW-1:0]        seg_done_cnt;
    logic signed [PW-1:0] prod_r;
    logic                 prod_v;
    logic                 prod_first;
    logic                 prod_last;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sum;
    logic [WORD_BITS-1:0] asm_word;
    logic [WORD_BITS-1:0] next_word;
    logic [BW-1:0]        bit_cnt;
    logic                 accept;
    logic                 decided_bit;
    logic                 word_load;

    assign ref_index = sample_cnt;

    // Stall only the sample that would complete a second word while the
    // first one is still unread; every other sample can safely enter the
    // pipeline because the holding register frees before it is needed.
    assign in_ready = !(bits_valid && !bits_ready &&
                        seg_done_cnt == LAST_SEG && sample_cnt == LAST_SAMPLE);
    assign accept   = in_valid && in_ready;

    // Accumulator restarts on the first product of each segment. The extra
    // IW bits guarantee SEG_LEN full-scale products cannot wrap.
    always_comb begin
        acc_base    = prod_first ? '0 : acc;
        sum         = acc_base + AW'(prod_r);
        decided_bit = !sum[AW-1];
        next_word   = {asm_word[WORD_BITS-2:0], decided_bit};
        word_load   = prod_v && prod_last && (bit_cnt == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_cnt   <= '0;
            seg_done_cnt <= '0;
            prod_r       <= '0;
            prod_v       <= 1'b0;
            prod_first   <= 1'b0;
            prod_last    <= 1'b0;
            acc          <= '0;
            asm_word     <= '0;
            bit_cnt      <= '0;
            bits_out     <= '0;
            bits_valid   <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_r     <= PW'(sample_in) * PW'(ref_sample_in);
                prod_first <= (sample_cnt == '0);
                prod_last  <= (sample_cnt == LAST_SAMPLE);
                if (sample_cnt == LAST_SAMPLE) begin
                    sample_cnt   <= '0;
                    seg_done_cnt <= (seg_done_cnt == LAST_SEG) ? '0 : seg_done_cnt + SW'(1);
                end else begin
                    sample_cnt <= sample_cnt + IW'(1);
                end
            end

            if (prod_v) begin
                acc <= sum;
                if (prod_last) begin
                    if (bit_cnt == LAST_BIT) begin
                        asm_word <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        asm_word <= next_word;
                        bit_cnt  <= bit_cnt + BW'(1);
                    end
                end
            end

            // A fresh word wins over a same-edge handshake, so valid stays high
            // with new data; otherwise a handshake empties the holding register.
            if (word_load) begin
                bits_out   <= next_word;
                bits_valid <= 1'b1;
            end else if (bits_ready) begin
                bits_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_corr_demod.sv
// tb_seg_corr_demod
// Scoreboard bench for seg_corr_demod with SEG_LEN=4, WORD_BITS=8. Expected
// words are pushed when a word's samples are issued; a monitor pops one on
// every output handshake. Expected words come either from constants for
// directed patterns or from a plain-arithmetic correlation model.
module tb_seg_corr_demod;

    localparam int DW          = 32;
    localparam int SL          = 4;
    localparam int WB          = 8;
    localparam int IW          = 2;
    localparam int NS          = SL * WB;
    localparam int STALL_LIMIT = 200;

    typedef logic signed [DW-1:0] seg_arr_t [NS];
    typedef logic signed [DW-1:0] tbl_t [SL];

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] sample_in;
    logic signed [DW-1:0] ref_sample_in;
    logic [IW-1:0]        ref_index;
    logic [WB-1:0]        bits_out;
    logic                 bits_valid;
    logic                 bits_ready;

    tbl_t          ref_table;
    logic [WB-1:0] exp_q[$];
    int            tests_run = 0;
    int            failures  = 0;
    int            exp_index = 0;
    bit            rand_ready = 0;

    seg_corr_demod #(.DW(DW), .SEG_LEN(SL), .WORD_BITS(WB)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sample_in    (sample_in),
        .ref_sample_in(ref_sample_in),
        .ref_index    (ref_index),
        .bits_out     (bits_out),
        .bits_valid   (bits_valid),
        .bits_ready   (bits_ready)
    );

    // External reference table indexed by the DUT
    assign ref_sample_in = ref_table[ref_index];

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Correlate each segment against the table; sum >= 0 means bit 1
    function automatic logic [WB-1:0] model_word(input seg_arr_t smp, input tbl_t tbl);
        logic [WB-1:0]       w;
        logic signed [127:0] corr;
        longint              a;
        longint              b;
        w = '0;
        for (int bi = 0; bi < WB; bi++) begin
            corr = '0;
            for (int k = 0; k < SL; k++) begin
                a    = longint'(smp[bi*SL+k]);
                b    = longint'(tbl[k]);
                corr = corr + 128'(a * b);
            end
            w = {w[WB-2:0], (corr >= 0)};
        end
        return w;
    endfunction

    // Modulator: +ref segment for a 1, -ref segment for a 0, MSB first
    function automatic seg_arr_t make_pm(input logic [WB-1:0] word, input tbl_t tbl);
        seg_arr_t r;
        for (int bi = 0; bi < WB; bi++)
            for (int k = 0; k < SL; k++)
                r[bi*SL+k] = word[WB-1-bi] ? tbl[k] : -tbl[k];
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the sample is accepted
    task automatic push_sample(input logic signed [DW-1:0] s, input int idle_pct,
                               output int stalls);
        stalls = 0;
        while (int'($urandom_range(99)) < idle_pct) begin
            in_valid = 0;
            if (rand_ready) bits_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        in_valid  = 1;
        sample_in = s;
        if (rand_ready) bits_ready = 1'($urandom_range(1));
        #1;
        while (!in_ready) begin
            stalls++;
            if (stalls > STALL_LIMIT) begin
                $display("[TB] FAIL in_ready timeout: got 0, required 1");
                $fatal(1, "[TB] stalled input");
            end
            @(posedge clk); #1;
            if (rand_ready) bits_ready = 1'b1;
            #1;
        end
        check_output("ref_index", 64'(ref_index), 64'(exp_index));
        @(posedge clk); #1;
        in_valid  = 0;
        exp_index = (exp_index + 1) % SL;
    endtask

    task automatic apply_stimulus(input seg_arr_t smp, input int count, input int idle_pct,
                                  input logic [WB-1:0] exp_word, input bit do_push,
                                  output int stalls);
        int st;
        stalls = 0;
        if (do_push) exp_q.push_back(exp_word);
        for (int i = 0; i < count; i++) begin
            push_sample(smp[i], idle_pct, st);
            stalls += st;
        end
    endtask

    initial begin : monitor
        logic [WB-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (reset && bits_valid && bits_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("[TB] FAIL unexpected word: got 0x%0h, required none", bits_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    check_output("word", 64'(bits_out), 64'(exp_w));
                end
            end
        end
    end

    initial begin : main
        seg_arr_t smp;
        seg_arr_t smp2;
        tbl_t     tbl;
        int       stalls;

        reset     = 0;
        in_valid  = 0;
        sample_in = '0;
        bits_ready = 1;
        for (int k = 0; k < SL; k++) ref_table[k] = 1000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check_output("reset bits_valid", 64'(bits_valid), 0);
        check_output("reset bits_out", 64'(bits_out), 0);
        check_output("reset ref_index", 64'(ref_index), 0);
        check_output("reset in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        // Directed 0xA5, continuous valid, latency and single-cycle valid
        smp = make_pm(8'hA5, ref_table);
        apply_stimulus(smp, NS, 0, 8'hA5, 1, stalls);
        check_output("t1 stalls", 64'(stalls), 0);
        check_output("t1 valid before E+1", 64'(bits_valid), 0);
        @(posedge clk); #1;
        check_output("t1 valid after E+1", 64'(bits_valid), 1);
        check_output("t1 bits_out", 64'(bits_out), 64'(8'hA5));
        @(posedge clk); #1;
        check_output("t1 valid drops", 64'(bits_valid), 0);

        // Full-scale products: a 64-bit accumulator would wrap here
        for (int k = 0; k < SL; k++) tbl[k] = (k % 2 == 0) ? 32'sh7FFF_FFFF : -32'sh7FFF_FFFF;
        ref_table = tbl;
        for (int i = 0; i < NS; i++) smp[i] = -tbl[i % SL];
        apply_stimulus(smp, NS, 0, 8'h00, 1, stalls);
        smp = make_pm(8'hC3, tbl);
        apply_stimulus(smp, NS, 0, 8'hC3, 1, stalls);

        // Zero correlation decides 1
        for (int k = 0; k < SL; k++) ref_table[k] = 1;
        for (int bi = 0; bi < WB; bi++)
            for (int k = 0; k < SL; k++)
                smp[bi*SL+k] = ((8'h5A >> (WB-1-bi)) & 1) != 0 ?
                               ((k % 2 == 0) ? 32'sd5 : -32'sd5) : -32'sd5;
        apply_stimulus(smp, NS, 0, 8'h5A, 1, stalls);

        // Backpressure: only the final sample of word 2 stalls
        for (int k = 0; k < SL; k++) ref_table[k] = 1000;
        repeat (3) @(posedge clk);
        #1;
        bits_ready = 0;
        smp = make_pm(8'hA5, ref_table);
        apply_stimulus(smp, NS, 0, 8'hA5, 1, stalls);
        smp2 = make_pm(8'h69, ref_table);
        apply_stimulus(smp2, NS - 1, 0, 8'h69, 1, stalls);
        check_output("t4 no early stall", 64'(stalls), 0);
        in_valid  = 1;
        sample_in = smp2[NS-1];
        for (int c = 0; c < 3; c++) begin
            #1;
            check_output("t4 in_ready low", 64'(in_ready), 0);
            check_output("t4 held word", 64'(bits_out), 64'(8'hA5));
            check_output("t4 held valid", 64'(bits_valid), 1);
            @(posedge clk); #1;
        end
        bits_ready = 1;
        push_sample(smp2[NS-1], 0, stalls);
        check_output("t4 release", 64'(stalls), 0);

        // Random idle gaps do not change the result
        smp = make_pm(8'h3C, ref_table);
        apply_stimulus(smp, NS, 30, 8'h3C, 1, stalls);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-word drops a pending unread word and partial segments
        bits_ready = 0;
        smp = make_pm(8'hFF, ref_table);
        apply_stimulus(smp, NS, 0, 8'h00, 0, stalls);
        smp = make_pm(8'h00, ref_table);
        apply_stimulus(smp, 2 * SL, 0, 8'h00, 0, stalls);
        reset = 0;
        @(posedge clk); #1;
        reset      = 1;
        exp_index  = 0;
        #1;
        check_output("t6 bits_valid", 64'(bits_valid), 0);
        check_output("t6 ref_index", 64'(ref_index), 0);
        check_output("t6 bits_out", 64'(bits_out), 0);
        bits_ready = 1;
        @(posedge clk); #1;
        smp = make_pm(8'h96, ref_table);
        apply_stimulus(smp, NS, 0, 8'h96, 1, stalls);

        // Random references, samples, gaps and sink backpressure
        rand_ready = 1;
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < SL; k++) tbl[k] = $urandom;
            ref_table = tbl;
            for (int i = 0; i < NS; i++) smp[i] = $urandom;
            apply_stimulus(smp, NS, 30, model_word(smp, tbl), 1, stalls);
        end
        rand_ready = 0;
        bits_ready = 1;

        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check_output("queue drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/seg_corr_demod.md
Name: seg_corr_demod

Overview:
- Receive-side counterpart of the per-bit segment modulator, which emits array_ref for bit 1 and array_ref_m (negated reference) for bit 0.
- Each received segment of SEG_LEN signed samples is correlated against the reference waveform, and one hard bit is decided per segment.
- Decided bits are packed MSB-first into WORD_BITS-wide words, delivered over a valid/ready output with input backpressure.
- Sits between the sample source (channel/ADC model) and the bit sink that checks against the modulator's input_bit word.

Parameters:
- DW, 32, signed sample and reference width.
- SEG_LEN, 16, samples per bit segment; must be >= 2.
- WORD_BITS, 32, decided bits per output word; must be >= 2.
- IW, $clog2(SEG_LEN), derived width of ref_index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  sample_in and ref_sample_in are valid.
- in_ready  out  1  block accepts a sample this cycle.
- sample_in  in  DW  received sample, signed.
- ref_sample_in  in  DW  reference sample for ref_index, signed, from the external reference table.
- ref_index  out  IW  position within the current segment; combinational from the sample counter.
- bits_out  out  WORD_BITS  decided word; first decided bit in the MSB.
- bits_valid  out  1  bits_out holds a complete word.
- bits_ready  in  1  sink accepts the word.

Behaviour:
- Clock and reset
  - Single clock, clk. Reset is synchronous and active-low: all state is cleared on a clk edge while reset==0.
  - Reset values: sample_cnt=0, seg_done_cnt=0, prod_v=0, acc=0, asm word=0, bit_cnt=0, bits_out=0, bits_valid=0, ref_index=0.
  - in_ready=1 as soon as reset is released.
  - Reset mid-segment or mid-word discards all partial work, including a pending unread word.
- Accept
  - A sample is accepted on a clk edge with in_valid && in_ready.
  - ref_index = sample_cnt. The external table supplies ref_sample_in in the same cycle.
- Stage 1, on accept
  - prod_r <= sample_in * ref_sample_in, full 2*DW signed.
  - prod_v <= 1; prod_first <= (sample_cnt==0); prod_last <= (sample_cnt==SEG_LEN-1).
  - sample_cnt increments, wrapping SEG_LEN-1 -> 0.
  - On the last sample of a segment, seg_done_cnt increments, wrapping WORD_BITS-1 -> 0.
  - With no accept, prod_v <= 0.
- Stage 2, when prod_v
  - acc is 2*DW+IW bits, signed.
  - sum = (prod_first ? 0 : acc) + sign-extended prod_r; acc <= sum.
  - If prod_last: bit = (sum >= 0), so a zero correlation decides 1.
  - The decided bit shifts into the asm word from the LSB side; bit_cnt increments.
  - When bit_cnt reaches WORD_BITS: bits_out <= completed word, bits_valid <= 1, bit_cnt <= 0, asm cleared.
- Latency
  - The word completes one edge after the edge that accepts its final sample: accept at edge E, bits_valid high after edge E+1.
  - Sustained throughput is 1 sample/cycle.
- Output handshake
  - bits_out and bits_valid are held stable while bits_valid && !bits_ready.
  - On bits_valid && bits_ready, bits_valid <= 0, unless a new word loads on the same edge, in which case it stays 1 with the new data.
- Backpressure
  - in_ready = !(bits_valid && !bits_ready && seg_done_cnt==WORD_BITS-1 && sample_cnt==SEG_LEN-1).
  - Only the sample that would complete a second word is stalled. No word is ever overwritten or dropped.
- Gaps: in_valid gaps of any length are allowed at any sample position and do not alter the result.
- Arithmetic: acc cannot overflow for any DW-bit inputs, since the width is 2*DW+IW.

Test Plan:
- Params DW=32, SEG_LEN=4, WORD_BITS=8. ref=+1000 constant; segments = +ref/-ref encoding 0xA5, continuous valid, bits_ready=1 -> bits_out=0xA5, bits_valid high for exactly 1 cycle, after the edge following the 32nd accept.
- Default params. ref = alternating +/-0x7FFF_FFFF; samples = -ref for all 32 segments -> bits_out=0x0000_0000; acc never wraps (bit 0 decided each time).
- Segment whose correlation sums to exactly 0 (samples +5,-5,+5,-5 against ref all +1) -> decided bit 1.
- bits_ready held 0 after first word 0xA5, stream continues -> in_ready drops exactly at the final sample of word 2. bits_out stays 0xA5. Raise bits_ready -> 0xA5 consumed, then word 2 delivered intact.
- Random in_valid gaps (30% idle) with pattern 0x3C -> same 0x3C output; ref_index sequence 0,1,2,3 repeating, advancing only on accepts.
- reset=0 for one edge after 2 segments of a word -> bits_valid=0, ref_index=0. A fresh full word afterwards decodes correctly with no stale bits.
